serial_bus_master_port: RTL
===========================

Name: serial_bus_master_port

Overview:
- Master-side companion to the serial-bus arbiter, one instance per bus master, sitting directly upstream of the arbiter's per-master request input.
- Turns a local level request from the master core into the single-wire request protocol the arbiter decodes, then waits for the arbiter's grant line.
- Sends the accept or decline frame, holds the bus during the transfer, and sends the release frame when the transfer ends.
- Exposes a clean `granted` level that the master core and the bus muxes use.

Parameters:
- MASTER_ID, 2'b01: 2-bit ID sent in the request frame. Must be nonzero, because 0 means "bus free" at the arbiter.
- GRANT_TIMEOUT, 16: maximum cycles spent in WAIT_GRANT or WAIT_DROP before aborting.
- IDLE_GAP, 3: minimum consecutive low cycles on arb_out before any new request frame.

Ports:
- clk  in  1  system clock; the single clock for the whole block.
- rst  in  1  reset, synchronous and active-high.
- req  in  1  master core wants the bus (level).
- done  in  1  single-cycle pulse from the master core: transfer finished.
- arb_in  in  1  grant line from the arbiter (the arbiter's mN_out); same clock domain, no synchroniser.
- arb_out  out  1  serial request line to the arbiter (the arbiter's mN_in); registered.
- granted  out  1  high only while this master owns the bus.
- busy  out  1  high whenever state is not IDLE.
- timeout  out  1  single-cycle pulse when a wait is aborted.
- nak_sent  out  1  single-cycle pulse when a decline frame completes.

Behaviour:
- Reset: all outputs 0, state IDLE, gap counter preset to IDLE_GAP so a request may start immediately after reset. Reset takes effect from any state, including mid-frame or mid-COM; arb_out is 0 on the cycle after rst is sampled high.
- Frame bit patterns, sent MSB first, one bit per cycle:
  - START = 111
  - ID = MASTER_ID
  - ACK = 101
  - NAK = 110
  - END = 01
- arb_out idles low. A frame is never truncated except by rst.
- IDLE: arb_out = 0; the gap counter increments while the line is low (saturating). If req = 1 and gap counter ≥ IDLE_GAP, go to REQ. The first START bit appears on arb_out the cycle after req is sampled.
- REQ: send START then ID (5 cycles), then go to WAIT_GRANT. A req drop during REQ does not abort the frame.
- WAIT_GRANT: arb_out = 0; the timeout counter runs.
  - arb_in = 1 and req = 1: go to ACK.
  - arb_in = 1 and req = 0: go to NAK.
  - Counter reaches GRANT_TIMEOUT with no grant: pulse timeout, go to IDLE with the gap counter cleared.
- ACK: send 101 (3 cycles), then go to COM.
- NAK: send 110 (3 cycles), then go to IDLE. nak_sent pulses on the cycle of the last NAK bit. granted is never asserted on this path.
- COM: arb_out held at 1; granted = 1 from the first COM cycle.
  - done = 1 or req = 0: go to RELEASE. granted drops the cycle after the event.
  - done pulses in any other state are ignored.
- RELEASE: send 01 (2 cycles), then go to WAIT_DROP.
- WAIT_DROP: arb_out = 0; the timeout counter runs.
  - arb_in = 0: go to IDLE with the gap counter cleared.
  - Timeout: pulse timeout, go to IDLE.
- Simultaneous events:
  - arb_in rising on the same cycle req falls in WAIT_GRANT: NAK wins.
  - done and rst together: rst wins.
- Counter widths:
  - Timeout counter: $clog2(GRANT_TIMEOUT+1) bits.
  - Gap counter: $clog2(IDLE_GAP+1) bits.
  - Both saturate, never wrap.
- Timeout counter clears on every state entry.

Decomposition:
- Package serial_bus_pkg holds:
  - START_PAT, ID_W = 2, ACK_PAT, NAK_PAT, END_PAT, so the arbiter and this block share one definition;
  - the port state enum (IDLE, REQ, WAIT_GRANT, ACK, NAK, COM, RELEASE, WAIT_DROP).
- One sub-module, serial_frame_tx: loads an up-to-5-bit pattern plus a length, shifts it out MSB first, and flags its last bit.

Test Plan:
1. MASTER_ID = 01, req held high:
   - arb_out = 1,1,1,0,1 then 0 while waiting.
   - arb_in raised 4 cycles later → arb_out = 1,0,1 then steady 1, granted = 1.
   - done pulse → arb_out = 0,1,0 and granted = 0 the cycle after done.
   - arb_in dropped → busy = 0.
2. MASTER_ID = 10 → START/ID frame reads 1,1,1,1,0 on arb_out.
3. GRANT_TIMEOUT = 16, arb_in held low:
   - timeout pulses exactly 16 cycles after WAIT_GRANT entry and arb_out stays 0.
   - With req still high, the next START begins only after 3 low cycles.
4. req dropped in WAIT_GRANT, then arb_in = 1 → arb_out = 1,1,0, nak_sent pulses once, granted stays 0, block returns to IDLE.
5. rst asserted on the third COM cycle → arb_out = 0, granted = 0, busy = 0 on the next cycle; a fresh request then reproduces test 1.
6. done pulsed during WAIT_GRANT is ignored; req dropped during COM behaves exactly like done (arb_out = 0,1 follows).

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared serial-bus framing constants and the master-port state type.
// The arbiter and the master port both import this so the frame patterns live in one place.
package serial_bus_pkg;

  localparam int ID_W    = 2;
  localparam int FRAME_W = 5;
  localparam int LEN_W   = 3;

  localparam logic [2:0] START_PAT = 3'b111;
  localparam logic [2:0] ACK_PAT   = 3'b101;
  localparam logic [2:0] NAK_PAT   = 3'b110;
  localparam logic [1:0] END_PAT   = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_GRANT,
    ACK,
    NAK,
    COM,
    RELEASE,
    WAIT_DROP
  } port_state_e;

  // START followed by the master ID, sent as one 5-bit frame
  function automatic logic [FRAME_W-1:0] req_frame(input logic [ID_W-1:0] id);
    return {START_PAT, id};
  endfunction

endpackage

// File: rtl/serial_bus_master_port_if.sv
// Master-core / arbiter-facing signals of one serial-bus master port.
// The port itself uses the master modport; the driving side (core + arbiter) uses slave.
interface serial_bus_master_port_if;

  logic req;
  logic done;
  logic arb_in;
  logic arb_out;
  logic granted;
  logic busy;
  logic timeout;
  logic nak_sent;

  modport master (
    input  req,
    input  done,
    input  arb_in,
    output arb_out,
    output granted,
    output busy,
    output timeout,
    output nak_sent
  );

  modport slave (
    output req,
    output done,
    output arb_in,
    input  arb_out,
    input  granted,
    input  busy,
    input  timeout,
    input  nak_sent
  );

endinterface

// File: rtl/serial_bus_master_port_frame_tx.sv
// Frame shifter: loads a right-aligned pattern of up to FRAME_W bits plus its length
// and shifts it out MSB first; reports the bit due on the line next cycle.
module serial_frame_tx
  import serial_bus_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               bit_next,
  output logic               last,
  output logic               last_next
);

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      // left-align so the MSB of the frame always leaves from the top bit
      shreg_d = pat << (LEN_W'(FRAME_W) - len);
      cnt_d   = len;
    end else if (cnt_q != '0) begin
      shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
      cnt_d   = cnt_q - LEN_W'(1);
    end
  end

  assign bit_next  = shreg_d[FRAME_W-1] & (cnt_d != '0);
  assign last      = (cnt_q == LEN_W'(1));
  assign last_next = (cnt_d == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_bus_master_port.sv
// Per-master serial-bus port: turns a level request into request/accept/decline/release
// frames on arb_out and tracks the arbiter's grant line to produce a clean granted level.
module serial_bus_master_port
  import serial_bus_pkg::*;
#(
  parameter logic [ID_W-1:0] MASTER_ID     = 2'b01,
  parameter int              GRANT_TIMEOUT = 16,
  parameter int              IDLE_GAP      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_bus_master_port_if.master bus
);

  localparam int TMR_W = $clog2(GRANT_TIMEOUT + 1);
  localparam int GAP_W = $clog2(IDLE_GAP + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(GRANT_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(IDLE_GAP);

  port_state_e        state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d, timer_inc;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               arb_out_q, arb_out_d;
  logic               granted_q, granted_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               nak_sent_q, nak_sent_d;

  logic               tx_load;
  logic [FRAME_W-1:0] tx_pat;
  logic [LEN_W-1:0]   tx_len;
  logic               tx_bit_next, tx_last, tx_last_next;

  serial_frame_tx u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .pat       (tx_pat),
    .len       (tx_len),
    .bit_next  (tx_bit_next),
    .last      (tx_last),
    .last_next (tx_last_next)
  );

  always_comb begin
    state_d   = state_q;
    timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
    timer_d   = timer_inc;
    // gap counts consecutive low cycles on the line, saturating
    gap_d     = arb_out_q ? '0 : ((gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1));
    timeout_d = 1'b0;
    tx_load   = 1'b0;
    tx_pat    = '0;
    tx_len    = '0;

    case (state_q)
      IDLE: begin
        if (bus.req && (gap_q >= GAP_MAX)) begin
          state_d = REQ;
          tx_load = 1'b1;
          tx_pat  = req_frame(MASTER_ID);
          tx_len  = LEN_W'(FRAME_W);
        end
      end
      REQ: begin
        if (tx_last) state_d = WAIT_GRANT;
      end
      WAIT_GRANT: begin
        // a req drop coinciding with the grant takes the decline path
        if (bus.arb_in) begin
          tx_load = 1'b1;
          tx_len  = LEN_W'(3);
          if (bus.req) begin
            state_d = ACK;
            tx_pat  = FRAME_W'(ACK_PAT);
          end else begin
            state_d = NAK;
            tx_pat  = FRAME_W'(NAK_PAT);
          end
        end else if (timer_inc == TMR_MAX) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          gap_d     = '0;
        end
      end
      ACK: begin
        if (tx_last) state_d = COM;
      end
      NAK: begin
        if (tx_last) state_d = IDLE;
      end
      COM: begin
        if (bus.done || !bus.req) begin
          state_d = RELEASE;
          tx_load = 1'b1;
          tx_pat  = FRAME_W'(END_PAT);
          tx_len  = LEN_W'(2);
        end
      end
      RELEASE: begin
        if (tx_last) state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!bus.arb_in) begin
          state_d = IDLE;
          gap_d   = '0;
        end else if (timer_inc == TMR_MAX) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;

    arb_out_d  = (state_d == COM) | tx_bit_next;
    granted_d  = (state_d == COM);
    busy_d     = (state_d != IDLE);
    nak_sent_d = (state_q == NAK) & tx_last_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      gap_q      <= GAP_MAX;
      arb_out_q  <= 1'b0;
      granted_q  <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      nak_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      arb_out_q  <= arb_out_d;
      granted_q  <= granted_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      nak_sent_q <= nak_sent_d;
    end
  end

  assign bus.arb_out  = arb_out_q;
  assign bus.granted  = granted_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;
  assign bus.nak_sent = nak_sent_q;

endmodule
